// File: rtl/axi_rr_arbiter_pkg.sv
// Shared constants for the NPC AXI arbiter: response codes, FSM encodings and master ids.
package axi_rr_arbiter_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_ADDR_DATA = 2'd1;
  localparam logic [1:0] W_RESP      = 2'd2;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/axi_rr_arbiter_if.sv
// One full AXI4 port (AR, R, AW, W, B). The IFU only uses the read half through rd_slave.
interface axi_rr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic       bvalid;
  logic       bready;
  logic [1:0] bresp;

  modport master (
    output arvalid, araddr, arlen, arsize, rready,
           awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, rready,
           awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );

  modport rd_slave (
    input  arvalid, araddr, arlen, arsize, rready,
    output arready, rvalid, rdata, rresp, rlast
  );

endinterface

// File: rtl/axi_rr_arbiter_grant.sv
// Two-requester round-robin picker. The winner is combinational; last_grant only moves
// when the caller reports a finished transaction, so a burst owner keeps priority until done.
module axi_rr_grant
  import axi_rr_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic       gnt,
  output logic       gnt_id
);

  logic last_grant_q;
  logic last_grant_d;

  // Pick a winner: a lone requester wins, on a tie the one that was not served last wins.
  always_comb begin
    gnt    = en && (req != 2'b00);
    gnt_id = MST_IFU;
    if (req == 2'b11) begin
      gnt_id = ~last_grant_q;
    end else if (req[1]) begin
      gnt_id = MST_LSU;
    end
    last_grant_d = done ? done_id : last_grant_q;
  end

  // Remember who finished last; reset (active-low) favours the LSU on the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= MST_IFU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/axi_rr_arbiter.sv
// IFU + LSU to SRAM AXI4 arbiter: round-robin read bursts with beat checking,
// LSU-only write path, optional read/write mutual exclusion. reset is active-low.
module axi_rr_arbiter
  import axi_rr_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter bit RW_EXCLUSIVE = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  axi_rr_arbiter_if.rd_slave         ifu_axi,
  axi_rr_arbiter_if.slave            mem_axi,
  axi_rr_arbiter_if.master           sram_axi,
  output logic                       burst_err
);

  logic [1:0] r_state_q,   r_state_d;
  logic       r_owner_q,   r_owner_d;
  logic [7:0] r_len_q,     r_len_d;
  logic [7:0] beat_cnt_q,  beat_cnt_d;
  logic       burst_err_q, burst_err_d;
  logic [1:0] w_state_q,   w_state_d;
  logic       aw_done_q,   aw_done_d;
  logic       w_done_q,    w_done_d;

  logic w_req, w_start, rd_en, gnt, gnt_id;
  logic ar_valid_sel, r_ready_sel;
  logic ar_hs, r_hs, r_done, aw_hs, w_hs, b_hs;

  logic [ADDR_W-1:0]   ar_addr_fwd;
  logic [DATA_W-1:0]   w_data_fwd;
  logic [DATA_W/8-1:0] w_strb_fwd;

  // Handshake decode and the read/write interlock; a pending write beats a pending read.
  always_comb begin
    w_req        = mem_axi.awvalid || mem_axi.wvalid;
    w_start      = (w_state_q == W_IDLE) && w_req && (!RW_EXCLUSIVE || (r_state_q == R_IDLE));
    rd_en        = (r_state_q == R_IDLE) && !(RW_EXCLUSIVE && ((w_state_q != W_IDLE) || w_req));
    ar_valid_sel = (r_owner_q == MST_LSU) ? mem_axi.arvalid : ifu_axi.arvalid;
    r_ready_sel  = (r_owner_q == MST_LSU) ? mem_axi.rready  : ifu_axi.rready;
    ar_hs        = (r_state_q == R_ADDR) && ar_valid_sel && sram_axi.arready;
    r_hs         = (r_state_q == R_DATA) && sram_axi.rvalid && r_ready_sel;
    r_done       = r_hs && sram_axi.rlast;
    aw_hs        = (w_state_q == W_ADDR_DATA) && !aw_done_q && mem_axi.awvalid && sram_axi.awready;
    w_hs         = (w_state_q == W_ADDR_DATA) && !w_done_q && mem_axi.wvalid && sram_axi.wready
                   && mem_axi.wlast;
    b_hs         = (w_state_q == W_RESP) && sram_axi.bvalid && mem_axi.bready;
  end

  axi_rr_grant u_grant (
    .clk     (clk),
    .reset   (reset),
    .en      (rd_en),
    .req     ({mem_axi.arvalid, ifu_axi.arvalid}),
    .done    (r_done),
    .done_id (r_owner_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  // Read FSM: register the grant, hold it through the burst, check beat count against arlen.
  always_comb begin
    r_state_d   = r_state_q;
    r_owner_d   = r_owner_q;
    r_len_d     = r_len_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = burst_err_q;
    case (r_state_q)
      R_IDLE: begin
        if (gnt) begin
          r_state_d = R_ADDR;
          r_owner_d = gnt_id;
          r_len_d   = (gnt_id == MST_LSU) ? mem_axi.arlen : ifu_axi.arlen;
        end
      end
      R_ADDR: begin
        if (ar_hs) begin
          r_state_d  = R_DATA;
          beat_cnt_d = 8'd0;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (sram_axi.rlast != (beat_cnt_q == r_len_q)) begin
            burst_err_d = 1'b1;
          end
          if (sram_axi.rlast) begin
            r_state_d = R_IDLE;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM: collect AW and last-W handshakes in any order, then wait for B.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: begin
        if (w_start) begin
          w_state_d = W_ADDR_DATA;
        end
      end
      W_ADDR_DATA: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          w_state_d = W_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
    endcase
  end

  // State registers for both channels and the sticky burst error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state_q   <= R_IDLE;
      r_owner_q   <= MST_IFU;
      r_len_q     <= 8'd0;
      beat_cnt_q  <= 8'd0;
      burst_err_q <= 1'b0;
      w_state_q   <= W_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      r_owner_q   <= r_owner_d;
      r_len_q     <= r_len_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_err_q <= burst_err_d;
      w_state_q   <= w_state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  assign burst_err = burst_err_q;

  // Read-side steering: AR from the owner in R_ADDR, R back to the owner in R_DATA, else quiet.
  always_comb begin
    ar_addr_fwd      = '0;
    sram_axi.arvalid = 1'b0;
    sram_axi.arlen   = 8'd0;
    sram_axi.arsize  = 3'd0;
    sram_axi.rready  = 1'b0;
    ifu_axi.arready  = 1'b0;
    ifu_axi.rvalid   = 1'b0;
    ifu_axi.rresp    = RESP_OKAY;
    ifu_axi.rlast    = 1'b0;
    ifu_axi.rdata    = sram_axi.rdata;
    mem_axi.arready  = 1'b0;
    mem_axi.rvalid   = 1'b0;
    mem_axi.rresp    = RESP_OKAY;
    mem_axi.rlast    = 1'b0;
    mem_axi.rdata    = sram_axi.rdata;
    case (r_state_q)
      R_ADDR: begin
        if (r_owner_q == MST_LSU) begin
          sram_axi.arvalid = mem_axi.arvalid;
          ar_addr_fwd      = mem_axi.araddr;
          sram_axi.arlen   = mem_axi.arlen;
          sram_axi.arsize  = mem_axi.arsize;
          mem_axi.arready  = sram_axi.arready;
        end else begin
          sram_axi.arvalid = ifu_axi.arvalid;
          ar_addr_fwd      = ifu_axi.araddr;
          sram_axi.arlen   = ifu_axi.arlen;
          sram_axi.arsize  = ifu_axi.arsize;
          ifu_axi.arready  = sram_axi.arready;
        end
      end
      R_DATA: begin
        sram_axi.rready = r_ready_sel;
        if (r_owner_q == MST_LSU) begin
          mem_axi.rvalid = sram_axi.rvalid;
          mem_axi.rresp  = sram_axi.rresp;
          mem_axi.rlast  = sram_axi.rlast;
        end else begin
          ifu_axi.rvalid = sram_axi.rvalid;
          ifu_axi.rresp  = sram_axi.rresp;
          ifu_axi.rlast  = sram_axi.rlast;
        end
      end
      default: begin
      end
    endcase
    sram_axi.araddr = ar_addr_fwd;
  end

  // Write-side steering: AW/W only while collecting (each closed once done), B only in W_RESP.
  always_comb begin
    w_data_fwd       = '0;
    w_strb_fwd       = '0;
    sram_axi.awvalid = 1'b0;
    sram_axi.awaddr  = '0;
    sram_axi.awlen   = 8'd0;
    sram_axi.awsize  = 3'd0;
    sram_axi.wvalid  = 1'b0;
    sram_axi.wlast   = 1'b0;
    sram_axi.bready  = 1'b0;
    mem_axi.awready  = 1'b0;
    mem_axi.wready   = 1'b0;
    mem_axi.bvalid   = 1'b0;
    mem_axi.bresp    = RESP_OKAY;
    case (w_state_q)
      W_ADDR_DATA: begin
        sram_axi.awvalid = mem_axi.awvalid && !aw_done_q;
        sram_axi.awaddr  = mem_axi.awaddr;
        sram_axi.awlen   = mem_axi.awlen;
        sram_axi.awsize  = mem_axi.awsize;
        mem_axi.awready  = sram_axi.awready && !aw_done_q;
        sram_axi.wvalid  = mem_axi.wvalid && !w_done_q;
        w_data_fwd       = mem_axi.wdata;
        w_strb_fwd       = mem_axi.wstrb;
        sram_axi.wlast   = mem_axi.wlast;
        mem_axi.wready   = sram_axi.wready && !w_done_q;
      end
      W_RESP: begin
        mem_axi.bvalid  = sram_axi.bvalid;
        mem_axi.bresp   = sram_axi.bresp;
        sram_axi.bready = mem_axi.bready;
      end
      default: begin
      end
    endcase
    sram_axi.wdata = w_data_fwd;
    sram_axi.wstrb = w_strb_fwd;
  end

endmodule

// File: doc/axi_rr_arbiter.md
Name: axi_rr_arbiter

Overview:
- Two-master to one-slave AXI4 arbiter for the NPC core. Masters are the IFU (read only) and the LSU (read and write); the slave is the SoC/SRAM port.
- Read channel: round-robin grant, held for a whole burst until the rlast handshake. Counts beats and flags burst-length violations.
- Write channel: LSU only, with independent AW/W acceptance tracking, complete on the B handshake.
- Optional read/write mutual exclusion protects simple slaves.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Write data and strobes pass through unmodified; lane placement is the LSU's job.
- RW_EXCLUSIVE, 1. When 1, a read and a write are never in flight at the same time.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-low reset.
- ifu_axi_arvalid/arready/araddr/arlen/arsize: in/out/in/in/in, 1/1/ADDR_W/8/3. IFU read address.
- ifu_axi_rvalid/rready/rdata/rresp/rlast: out/in/out/out/out, 1/1/DATA_W/2/1. IFU read data.
- mem_axi_arvalid/arready/araddr/arlen/arsize: in/out/in/in/in, same widths as IFU. LSU read address.
- mem_axi_rvalid/rready/rdata/rresp/rlast: out/in/out/out/out, same widths as IFU. LSU read data.
- mem_axi_awvalid/awready/awaddr/awlen/awsize: in/out/in/in/in, 1/1/ADDR_W/8/3. LSU write address.
- mem_axi_wvalid/wready/wdata/wstrb/wlast: in/out/in/in/in, 1/1/DATA_W/DATA_W/8/1. LSU write data.
- mem_axi_bvalid/bready/bresp: out/in/out, 1/1/2. LSU write response.
- sram_axi_*: mirror set of all the above channels, directions reversed.
- burst_err, out, 1: sticky burst protocol error.

Behaviour:
- Reset (asynchronous, low): all FSMs return to IDLE, last_grant=IFU, beat counter=0, burst_err=0.
  - All valid/ready outputs are 0 immediately.
  - Data, address and control outputs are 0 while not granted.
- Read FSM states:
  - R_IDLE: evaluate requests; the grant is registered. AR is forwarded on the cycle after arvalid is first seen, giving 1 cycle of arbitration latency.
    - Only one arvalid: grant that master.
    - Both: grant the master that is not last_grant.
    - Go to R_ADDR and latch owner and arlen.
    - With RW_EXCLUSIVE=1, stay in R_IDLE while the write FSM is not W_IDLE.
  - R_ADDR: forward the owner's AR channel to the slave; the owner's arready follows sram_axi_arready; the other master sees arready=0. On handshake go to R_DATA with beat counter=0.
  - R_DATA: forward the R channel to the owner only. The non-owner gets rvalid=0, rresp=0, rlast=0; rdata is forwarded unqualified to both. sram_axi_rready follows the owner's rready. Each handshake increments the beat counter. On an rlast handshake, set last_grant=owner and return to R_IDLE; a new grant is possible the following cycle.
- Burst check, evaluated on each R handshake:
  - rlast=1 with beat count != arlen sets burst_err.
  - beat count == arlen with rlast=0 sets burst_err. Keep accepting beats until rlast; completion is still signalled only by rlast.
  - burst_err clears only on reset.
- Write FSM states:
  - W_IDLE: on mem_axi_awvalid=1 or mem_axi_wvalid=1, go to W_ADDR_DATA next cycle. With RW_EXCLUSIVE=1 this also requires the read FSM to be in R_IDLE and not granting that cycle.
  - Simultaneous new read and write requests in the idle state with RW_EXCLUSIVE=1: the write wins and the read waits.
  - W_ADDR_DATA: forward AW and W (the W channel is forwarded only in this state). aw_done is set on the AW handshake; w_done is set on a W handshake with wlast=1. AW and W may complete in either order or in the same cycle. When both are done, go to W_RESP; once aw_done is set, awready to the LSU is forced to 0.
  - W_RESP: forward B. On the bvalid && bready handshake, go to W_IDLE and clear both done flags.
- RW_EXCLUSIVE=0: the read and write FSMs run independently.
- A master dropping valid before its handshake is an AXI violation; behaviour is unspecified and not checked.

Decomposition:
- Shared package constants:
  - AXI resp codes (OKAY=2'b00, SLVERR=2'b10).
  - Read state encodings R_IDLE/R_ADDR/R_DATA.
  - Write state encodings W_IDLE/W_ADDR_DATA/W_RESP.
  - Master ids MST_IFU=0, MST_LSU=1.
- One sub-module: axi_rr_grant, a two-requester round-robin grant with a last_grant register and enable input. It is reused by future DMA/CLINT arbitration.

Test Plan:
- Single IFU read, arlen=0, addr 0x8000_0000 → sram_axi_araddr=0x8000_0000 one cycle after arvalid; one beat with rlast=1 returned to the IFU; mem_axi_rvalid stays 0.
- IFU and LSU arvalid in the same cycle repeatedly, last_grant=IFU after reset → grants go LSU, IFU, LSU, IFU, with no overlap between bursts.
- LSU 4-beat read (arlen=3) with rready toggled 1,0,1,1,0,1 → exactly 4 handshakes accepted; grant released only after the rlast beat; burst_err=0.
- Slave asserts rlast on beat 2 of arlen=3 → burst_err=1, read FSM returns to R_IDLE, next read proceeds normally.
- LSU write with W presented 2 cycles before AW, wstrb=4'b0011, wdata=0x0000_BEEF → forwarded unchanged; bvalid reaches the LSU only after both AW and W have handshaken; with RW_EXCLUSIVE=1, a concurrent IFU read waits until the B handshake.
- reset driven low mid-burst in R_DATA → all valid/ready outputs are 0 in the same cycle; after release the arbiter is in R_IDLE and accepts a new read.
